bus_rr_arbiter: RTL and testbench

- Round-robin arbiter for the shared 32-bit system bus: up to 8 masters/slaves raise req, exactly one receives ack.
- Drives a registered select index that the bus/ctrl output mux consumes; the mux itself is not part of this block.
- Adds fair rotation, a turnaround cycle between owners, and a hold-time watchdog so a stuck requester cannot lock the bus.

---
 rtl/bus_rr_arbiter.sv | 103 ++++++++++
 tb/tb_bus_rr_arbiter.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/bus_rr_arbiter.sv
// Round-robin bus arbiter: one-hot grant, one-cycle turnaround between owners,
// and a hold-time watchdog that revokes a grant held for MAX_HOLD cycles.
module bus_rr_arbiter #(
  parameter int N_REQ      = 8,
  parameter int SEL_WIDTH  = 3,
  parameter int MAX_HOLD   = 256,
  parameter int HOLD_WIDTH = 9
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N_REQ-1:0]     req,
  output logic [N_REQ-1:0]     ack,
  output logic [SEL_WIDTH-1:0] sel,
  output logic                 bus_busy,
  output logic                 timeout,
  output logic [SEL_WIDTH-1:0] timeout_id
);

  // state   | meaning
  // S_IDLE  | no owner; grant the next requester after last owner
  // S_GRANT | sel owns the bus; watch for release or hold expiry
  // S_TURN  | one dead cycle so two owners never drive the bus together
  typedef enum logic [1:0] {S_IDLE, S_GRANT, S_TURN} state_t;

  state_t                r_state;
  logic [SEL_WIDTH-1:0]  r_last;
  logic [HOLD_WIDTH-1:0] r_hold;

  logic [SEL_WIDTH-1:0]  w_start;
  logic [N_REQ-1:0]      w_rot;
  logic [SEL_WIDTH-1:0]  w_off;
  logic [SEL_WIDTH:0]    w_sum;
  logic [SEL_WIDTH-1:0]  w_winner;
  logic                  w_found;
  logic                  w_hold_max;

  // Rotate req so the requester just after the last owner sits at bit 0.
  always_comb begin
    w_start  = (r_last == SEL_WIDTH'(N_REQ - 1)) ? '0 : r_last + 1'b1;
    w_rot    = N_REQ'({req, req} >> w_start);
    w_found  = 1'b0;
    w_off    = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (w_rot[i]) begin
        w_found = 1'b1;
        w_off   = SEL_WIDTH'(i);
      end
    end
    w_sum = {1'b0, w_start} + {1'b0, w_off};
    if (w_sum >= (SEL_WIDTH + 1)'(N_REQ))
      w_winner = SEL_WIDTH'(w_sum - (SEL_WIDTH + 1)'(N_REQ));
    else
      w_winner = w_sum[SEL_WIDTH-1:0];
  end

  assign w_hold_max = (MAX_HOLD != 0) && (r_hold == HOLD_WIDTH'(MAX_HOLD));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_last     <= SEL_WIDTH'(N_REQ - 1);
      r_hold     <= '0;
      ack        <= '0;
      sel        <= '0;
      bus_busy   <= 1'b0;
      timeout    <= 1'b0;
      timeout_id <= '0;
    end else begin
      timeout <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_found) begin
            ack      <= N_REQ'(1) << w_winner;
            sel      <= w_winner;
            bus_busy <= 1'b1;
            r_last   <= w_winner;
            r_hold   <= HOLD_WIDTH'(1);
            r_state  <= S_GRANT;
          end
        end
        S_GRANT: begin
          // Release takes priority over an expiry on the same edge.
          if (!req[sel]) begin
            ack      <= '0;
            bus_busy <= 1'b0;
            r_state  <= S_TURN;
          end else if (w_hold_max) begin
            ack        <= '0;
            bus_busy   <= 1'b0;
            timeout    <= 1'b1;
            timeout_id <= sel;
            r_state    <= S_TURN;
          end else begin
            r_hold <= r_hold + 1'b1;
          end
        end
        S_TURN:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bus_rr_arbiter.sv
// Bench for bus_rr_arbiter: directed vector table, watchdog sequences, and a
// randomized run against a cycle-level reference model (MAX_HOLD=256 and 4).
module tb_bus_rr_arbiter;

  logic       clk;
  logic       rst;
  logic [7:0] req;
  logic [7:0] ack_a, ack_b;
  logic [2:0] sel_a, sel_b, tid_a, tid_b;
  logic       busy_a, busy_b, to_a, to_b;

  int checks = 0;
  int errors = 0;

  bus_rr_arbiter #(.N_REQ(8), .SEL_WIDTH(3), .MAX_HOLD(256), .HOLD_WIDTH(9)) dut_a (
    .clk(clk), .rst(rst), .req(req), .ack(ack_a), .sel(sel_a),
    .bus_busy(busy_a), .timeout(to_a), .timeout_id(tid_a));

  bus_rr_arbiter #(.N_REQ(8), .SEL_WIDTH(3), .MAX_HOLD(4), .HOLD_WIDTH(3)) dut_b (
    .clk(clk), .rst(rst), .req(req), .ack(ack_b), .sel(sel_b),
    .bus_busy(busy_b), .timeout(to_b), .timeout_id(tid_b));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: owner index (-1 = none), skip count for the dead cycle.
  int m_owner [2];
  int m_last  [2];
  int m_held  [2];
  int m_skip  [2];
  int m_sel   [2];
  int m_tid   [2];
  int m_to    [2];

  int wait_cnt_a [8];
  int wait_cnt_b [8];
  int max_wait_a = 0;
  int max_wait_b = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  function automatic logic [31:0] pk(input logic [7:0] a, input logic [2:0] s,
                                     input logic b, input logic t, input logic [2:0] id);
    return {16'h0, a, s, b, t, id};
  endfunction

  task automatic model_step(input int m, input int maxh, input logic [7:0] rq, input logic rs);
    bit done;
    if (rs) begin
      m_owner[m] = -1; m_last[m] = 7; m_held[m] = 0; m_skip[m] = 0;
      m_sel[m] = 0; m_tid[m] = 0; m_to[m] = 0;
    end else begin
      m_to[m] = 0;
      if (m_owner[m] >= 0) begin
        if (!rq[m_owner[m]]) begin
          m_owner[m] = -1; m_skip[m] = 1;
        end else if (maxh != 0 && m_held[m] == maxh) begin
          m_to[m] = 1; m_tid[m] = m_owner[m]; m_owner[m] = -1; m_skip[m] = 1;
        end else begin
          m_held[m]++;
        end
      end else if (m_skip[m] > 0) begin
        m_skip[m] = 0;
      end else begin
        done = 0;
        for (int k = 1; k <= 8; k++) begin
          int idx;
          idx = (m_last[m] + k) % 8;
          if (!done && rq[idx]) begin
            done = 1; m_owner[m] = idx; m_last[m] = idx; m_sel[m] = idx; m_held[m] = 1;
          end
        end
      end
    end
  endtask

  function automatic logic [31:0] model_pk(input int m);
    logic [7:0] a;
    a = (m_owner[m] >= 0) ? 8'(1 << m_owner[m]) : 8'h00;
    return pk(a, 3'(m_sel[m]), (m_owner[m] >= 0), m_to[m] != 0, 3'(m_tid[m]));
  endfunction

  task automatic tick();
    logic [7:0] rq;
    logic       rs;
    rq = req; rs = rst;
    @(posedge clk);
    model_step(0, 256, rq, rs);
    model_step(1, 4, rq, rs);
    #1;
    chk("model_a", pk(ack_a, sel_a, busy_a, to_a, tid_a), model_pk(0));
    chk("model_b", pk(ack_b, sel_b, busy_b, to_b, tid_b), model_pk(1));
    chk("onehot_a", 32'($onehot0(ack_a)), 32'd1);
    chk("onehot_b", 32'($onehot0(ack_b)), 32'd1);
    for (int i = 0; i < 8; i++) begin
      if (!rs && rq[i] && !ack_a[i]) wait_cnt_a[i]++; else wait_cnt_a[i] = 0;
      if (!rs && rq[i] && !ack_b[i]) wait_cnt_b[i]++; else wait_cnt_b[i] = 0;
      if (wait_cnt_a[i] > max_wait_a) max_wait_a = wait_cnt_a[i];
      if (wait_cnt_b[i] > max_wait_b) max_wait_b = wait_cnt_b[i];
    end
  endtask

  task automatic chk_b(input string name, input logic [7:0] ea, input logic [2:0] es,
                       input logic et, input logic [2:0] eid);
    chk(name, pk(ack_b, sel_b, busy_b, to_b, tid_b), pk(ea, es, (ea != 8'h00), et, eid));
  endtask

  typedef struct {
    logic       rst;
    logic [7:0] req;
    logic [7:0] ack;
    logic [2:0] sel;
    logic       busy;
  } vec_t;

  vec_t tbl [42];

  function automatic vec_t v(input logic r, input logic [7:0] q, input logic [7:0] a,
                             input logic [2:0] s, input logic b);
    vec_t x;
    x.rst = r; x.req = q; x.ack = a; x.sel = s; x.busy = b;
    return x;
  endfunction

  initial begin
    rst = 1'b1;
    req = 8'h00;

    // Single owner 7, rotation 0->4->7->0, wrap past 7, reset mid-grant.
    tbl[0]  = v(1, 8'h00, 8'h00, 0, 0);
    for (int i = 1; i <= 5; i++) tbl[i] = v(0, 8'h80, 8'h80, 7, 1);
    tbl[6]  = v(0, 8'h00, 8'h00, 7, 0);
    tbl[7]  = v(0, 8'h00, 8'h00, 7, 0);
    tbl[8]  = v(0, 8'h00, 8'h00, 7, 0);
    for (int i = 9; i <= 11; i++) tbl[i] = v(0, 8'h91, 8'h01, 0, 1);
    tbl[12] = v(0, 8'h90, 8'h00, 0, 0);
    tbl[13] = v(0, 8'h91, 8'h00, 0, 0);
    for (int i = 14; i <= 16; i++) tbl[i] = v(0, 8'h91, 8'h10, 4, 1);
    tbl[17] = v(0, 8'h81, 8'h00, 4, 0);
    tbl[18] = v(0, 8'h91, 8'h00, 4, 0);
    for (int i = 19; i <= 21; i++) tbl[i] = v(0, 8'h91, 8'h80, 7, 1);
    tbl[22] = v(0, 8'h11, 8'h00, 7, 0);
    tbl[23] = v(0, 8'h91, 8'h00, 7, 0);
    tbl[24] = v(0, 8'h91, 8'h01, 0, 1);
    tbl[25] = v(0, 8'h00, 8'h00, 0, 0);
    tbl[26] = v(0, 8'h00, 8'h00, 0, 0);
    tbl[27] = v(0, 8'h20, 8'h20, 5, 1);
    tbl[28] = v(0, 8'h00, 8'h00, 5, 0);
    tbl[29] = v(0, 8'h21, 8'h00, 5, 0);
    tbl[30] = v(0, 8'h21, 8'h01, 0, 1);
    tbl[31] = v(0, 8'h20, 8'h00, 0, 0);
    tbl[32] = v(0, 8'h20, 8'h00, 0, 0);
    tbl[33] = v(0, 8'h20, 8'h20, 5, 1);
    tbl[34] = v(0, 8'h00, 8'h00, 5, 0);
    tbl[35] = v(0, 8'h00, 8'h00, 5, 0);
    tbl[36] = v(0, 8'h08, 8'h08, 3, 1);
    tbl[37] = v(0, 8'h08, 8'h08, 3, 1);
    tbl[38] = v(1, 8'h08, 8'h00, 0, 0);
    tbl[39] = v(0, 8'h0C, 8'h04, 2, 1);
    tbl[40] = v(0, 8'h00, 8'h00, 2, 0);
    tbl[41] = v(0, 8'h00, 8'h00, 2, 0);

    for (int i = 0; i < 42; i++) begin
      rst = tbl[i].rst;
      req = tbl[i].req;
      tick();
      chk($sformatf("tbl[%0d]", i), pk(ack_a, sel_a, busy_a, to_a, 3'(0)),
          pk(tbl[i].ack, tbl[i].sel, tbl[i].busy, 1'b0, 3'(0)));
    end

    // Watchdog: owner 4 holds forever, revoked after 4 cycles, regranted.
    rst = 1'b1; tick(); rst = 1'b0;
    req = 8'h10;
    for (int i = 0; i < 4; i++) begin tick(); chk_b("wd_hold", 8'h10, 3'd4, 1'b0, 3'd0); end
    tick(); chk_b("wd_revoke", 8'h00, 3'd4, 1'b1, 3'd4);
    tick(); chk_b("wd_idle", 8'h00, 3'd4, 1'b0, 3'd4);
    tick(); chk_b("wd_regrant", 8'h10, 3'd4, 1'b0, 3'd4);

    // Watchdog fairness: pending requester 1 is served before 4 again.
    rst = 1'b1; tick(); rst = 1'b0;
    req = 8'h10;
    tick(); chk_b("wf_grant4", 8'h10, 3'd4, 1'b0, 3'd0);
    req = 8'h12;
    for (int i = 0; i < 3; i++) begin tick(); chk_b("wf_hold4", 8'h10, 3'd4, 1'b0, 3'd0); end
    tick(); chk_b("wf_revoke4", 8'h00, 3'd4, 1'b1, 3'd4);
    tick(); chk_b("wf_idle4", 8'h00, 3'd4, 1'b0, 3'd4);
    for (int i = 0; i < 4; i++) begin tick(); chk_b("wf_hold1", 8'h02, 3'd1, 1'b0, 3'd4); end
    tick(); chk_b("wf_revoke1", 8'h00, 3'd1, 1'b1, 3'd1);
    tick(); chk_b("wf_idle1", 8'h00, 3'd1, 1'b0, 3'd1);
    tick(); chk_b("wf_regrant4", 8'h10, 3'd4, 1'b0, 3'd1);

    // Release on the same edge the hold limit is reached: no timeout.
    rst = 1'b1; tick(); rst = 1'b0;
    req = 8'h10;
    for (int i = 0; i < 4; i++) begin tick(); chk_b("rt_hold", 8'h10, 3'd4, 1'b0, 3'd0); end
    req = 8'h00;
    tick(); chk_b("rt_release", 8'h00, 3'd4, 1'b0, 3'd0);
    tick();

    // Randomized traffic: requesters hold until served, then release randomly.
    rst = 1'b1; tick(); rst = 1'b0;
    max_wait_a = 0; max_wait_b = 0;
    for (int c = 0; c < 10000; c++) begin
      for (int i = 0; i < 8; i++) begin
        if (!req[i]) begin
          if ($urandom_range(3) == 0) req[i] = 1'b1;
        end else if (ack_a[i] || ack_b[i]) begin
          if ($urandom_range(7) == 0) req[i] = 1'b0;
        end else if ($urandom_range(63) == 0) begin
          req[i] = 1'b0;
        end
      end
      rst = ($urandom_range(1999) == 0);
      tick();
    end
    rst = 1'b0;
    chk("starve_a", 32'(max_wait_a <= 8 * (256 + 2)), 32'd1);
    chk("starve_b", 32'(max_wait_b <= 8 * (4 + 2)), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
